// File: rtl/fix_parser_pkg.sv
// Shared constants and state encoding for the FIX pair drain sequencer.
package fix_parser_pkg;

  localparam logic [31:0] TAG_BEGIN    = 32'h0000_0038;  // "8"
  localparam logic [31:0] TAG_CHECKSUM = 32'h0000_3130;  // "10"

  localparam int DEF_TAG_W      = 32;
  localparam int DEF_VAL_W      = 256;
  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_FCNT_W     = 8;
  localparam int DEF_MCNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    CAP,
    PRESENT
  } drain_state_e;

endpackage

// File: rtl/fix_pair_classify.sv
// Combinational tag compare: flags message-begin and checksum (end) tags.
module fix_pair_classify
  import fix_parser_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic [TAG_W-1:0] tag_i,
  output logic             is_begin_o,
  output logic             is_end_o
);

  assign is_begin_o = (tag_i == TAG_W'(TAG_BEGIN));
  assign is_end_o   = (tag_i == TAG_W'(TAG_CHECKSUM));

endmodule

// File: rtl/fix_pair_drain_ctrl.sv
// Pops tag/value FIFOs in lockstep, re-pairs them and presents each pair
// downstream with FIX framing flags, field/message counts and sticky errors.
module fix_pair_drain_ctrl
  import fix_parser_pkg::*;
#(
  parameter int TAG_W      = DEF_TAG_W,
  parameter int VAL_W      = DEF_VAL_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int FCNT_W     = DEF_FCNT_W,
  parameter int MCNT_W     = DEF_MCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              t_empty_i,
  input  logic [TAG_W-1:0]  t_data_i,
  output logic              t_rd_cs_o,
  output logic              t_rd_en_o,
  input  logic              v_empty_i,
  input  logic [VAL_W-1:0]  v_data_i,
  output logic              v_rd_cs_o,
  output logic              v_rd_en_o,
  output logic              pair_valid_o,
  input  logic              pair_ready_i,
  output logic [TAG_W-1:0]  pair_tag_o,
  output logic [VAL_W-1:0]  pair_value_o,
  output logic              sof_o,
  output logic              eom_o,
  output logic [FCNT_W-1:0] field_cnt_o,
  output logic [MCNT_W-1:0] msg_cnt_o,
  output logic              err_no_hdr_o,
  output logic              err_trunc_o,
  output logic              err_ovf_o,
  output logic              busy_o
);

  localparam int                WCNT_W    = 2;
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(RD_LATENCY - 1);

  drain_state_e      state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              in_msg_q;
  logic              rd_q;
  logic              valid_q;
  logic              sof_q;
  logic              eom_q;
  logic [TAG_W-1:0]  tag_q;
  logic [VAL_W-1:0]  value_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [MCNT_W-1:0] mcnt_q;
  logic              err_no_hdr_q;
  logic              err_trunc_q;
  logic              err_ovf_q;

  logic              is_begin;
  logic              is_end;
  logic              fcnt_full;

  // Classification works on the captured tag so CAP sees stable data.
  fix_pair_classify #(.TAG_W(TAG_W)) u_classify (
    .tag_i      (tag_q),
    .is_begin_o (is_begin),
    .is_end_o   (is_end)
  );

  assign fcnt_full = &fcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      in_msg_q     <= 1'b0;
      rd_q         <= 1'b0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eom_q        <= 1'b0;
      tag_q        <= '0;
      value_q      <= '0;
      fcnt_q       <= '0;
      mcnt_q       <= '0;
      err_no_hdr_q <= 1'b0;
      err_trunc_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && !t_empty_i && !v_empty_i) begin
            state_q <= POP;
            rd_q    <= 1'b1;
          end
        end
        POP: begin
          wcnt_q  <= WAIT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          // Sample on the last wait cycle, when read data is valid.
          if (wcnt_q == '0) begin
            tag_q   <= t_data_i;
            value_q <= v_data_i;
            state_q <= CAP;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        CAP: begin
          if (is_begin) begin
            sof_q       <= 1'b1;
            eom_q       <= 1'b0;
            err_trunc_q <= err_trunc_q | in_msg_q;
            in_msg_q    <= 1'b1;
            fcnt_q      <= FCNT_W'(1);
            valid_q     <= 1'b1;
            state_q     <= PRESENT;
          end else if (!in_msg_q) begin
            err_no_hdr_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            sof_q <= 1'b0;
            eom_q <= is_end;
            if (fcnt_full) err_ovf_q <= 1'b1;
            else           fcnt_q    <= fcnt_q + FCNT_W'(1);
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (pair_ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            if (eom_q) begin
              in_msg_q <= 1'b0;
              mcnt_q   <= mcnt_q + MCNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign t_rd_cs_o    = rd_q;
  assign t_rd_en_o    = rd_q;
  assign v_rd_cs_o    = rd_q;
  assign v_rd_en_o    = rd_q;
  assign pair_valid_o = valid_q;
  assign pair_tag_o   = tag_q;
  assign pair_value_o = value_q;
  assign sof_o        = sof_q;
  assign eom_o        = eom_q;
  assign field_cnt_o  = fcnt_q;
  assign msg_cnt_o    = mcnt_q;
  assign err_no_hdr_o = err_no_hdr_q;
  assign err_trunc_o  = err_trunc_q;
  assign err_ovf_o    = err_ovf_q;
  assign busy_o       = (state_q != IDLE);

endmodule
